// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores on the req/ack data bus, aligns and
// extends load data, and produces the MEM/WB payload.
package mem_stage_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_t;

  typedef struct packed {
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    mem_op_t         mem_op;
  } wb_params_t;
endpackage

module mem_stage #(
  parameter int unsigned XLEN    = mem_stage_pkg::XLEN,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  input  logic [1:0]               ex_mem_op,
  input  logic [1:0]               ex_size,
  input  logic                     ex_signed,
  input  logic [XLEN-1:0]          ex_addr,
  input  logic [XLEN-1:0]          ex_store_data,
  input  logic [4:0]               ex_rd_addr,
  output logic                     stall,
  output logic                     mem_fault,
  output logic                     dbus_req,
  output logic                     dbus_we,
  output logic [XLEN-1:0]          dbus_addr,
  output logic [3:0]               dbus_be,
  output logic [XLEN-1:0]          dbus_wdata,
  input  logic                     dbus_ack,
  input  logic [XLEN-1:0]          dbus_rdata,
  output mem_stage_pkg::wb_params_t wb_params_out
);
  import mem_stage_pkg::*;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      rd_q;
  logic            store_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [1:0]      lo_q;
  logic [XLEN-1:0] rdata_q;
  logic            abort_q;

  logic            is_mem, misalign, start, fault_mis, to_hit;
  logic [XLEN-1:0] lane_sh, load_data;

  assign is_mem    = (ex_mem_op == MEM_OP_LOAD) || (ex_mem_op == MEM_OP_STORE);
  assign misalign  = (ex_size == 2'd1) ? ex_addr[0]
                   : (ex_size == 2'd0) ? 1'b0
                   : (ex_addr[1:0] != 2'b00);
  assign start     = (state_q == IDLE) && ex_valid && !abort_q && is_mem && !misalign;
  assign fault_mis = (state_q == IDLE) && ex_valid && !abort_q && is_mem && misalign;
  assign to_hit    = (state_q == REQ) && !dbus_ack && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    lane_sh = rdata_q >> {lo_q, 3'b000};
    case (size_q)
      2'd0:    load_data = {{(XLEN-8){signed_q & lane_sh[7]}}, lane_sh[7:0]};
      2'd1:    load_data = {{(XLEN-16){signed_q & lane_sh[15]}}, lane_sh[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  // The cycle after a timeout still sees the aborted instruction in EX/MEM;
  // abort_q makes IDLE let it advance without re-issuing it.
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    wb_params_out = '{rd_addr: '0, rd_data: '0, mem_op: MEM_OP_NONE};
    case (state_q)
      IDLE: begin
        if (ex_valid && !abort_q) begin
          if (!is_mem) begin
            wb_params_out = '{rd_addr: ex_rd_addr, rd_data: ex_addr, mem_op: MEM_OP_NONE};
          end else if (!misalign) begin
            stall   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dbus_ack)    state_d = DONE;
        else if (to_hit) state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
        if (store_q)
          wb_params_out = '{rd_addr: '0, rd_data: '0, mem_op: MEM_OP_STORE};
        else
          wb_params_out = '{rd_addr: rd_q, rd_data: load_data, mem_op: MEM_OP_LOAD};
      end
      default: state_d = IDLE;
    endcase
    // Outputs read as reset values while rst_n is held low, whatever EX presents.
    if (!rst_n) begin
      stall         = 1'b0;
      wb_params_out = '{rd_addr: '0, rd_data: '0, mem_op: MEM_OP_NONE};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      store_q    <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      lo_q       <= '0;
      rdata_q    <= '0;
      abort_q    <= 1'b0;
      mem_fault  <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
    end else begin
      state_q   <= state_d;
      mem_fault <= fault_mis | to_hit;
      abort_q   <= to_hit;
      if (start) begin
        rd_q      <= ex_rd_addr;
        store_q   <= (ex_mem_op == MEM_OP_STORE);
        size_q    <= ex_size;
        signed_q  <= ex_signed;
        lo_q      <= ex_addr[1:0];
        cnt_q     <= '0;
        dbus_req  <= 1'b1;
        dbus_we   <= (ex_mem_op == MEM_OP_STORE);
        dbus_addr <= {ex_addr[XLEN-1:2], 2'b00};
        case (ex_size)
          2'd0: begin
            dbus_be    <= 4'b0001 << ex_addr[1:0];
            dbus_wdata <= {4{ex_store_data[7:0]}};
          end
          2'd1: begin
            dbus_be    <= 4'b0011 << ex_addr[1:0];
            dbus_wdata <= {2{ex_store_data[15:0]}};
          end
          default: begin
            dbus_be    <= 4'b1111;
            dbus_wdata <= ex_store_data;
          end
        endcase
      end else if (state_q == REQ) begin
        if (dbus_ack) begin
          rdata_q  <= dbus_rdata;
          dbus_req <= 1'b0;
        end else if (to_hit) begin
          dbus_req <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: default instance plus a TIMEOUT=4 instance.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_mem_op = 2'd0;
  logic [1:0]  ex_size = 2'd0;
  logic        ex_signed = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic        dbus_ack = 1'b0, dbus_ack_to = 1'b0;
  logic [31:0] dbus_rdata = '0;

  logic        stall, mem_fault, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  wb_params_t  wb;
  logic        stall_to, fault_to, req_to, we_to;
  logic [31:0] addr_to, wdata_to;
  logic [3:0]  be_to;
  wb_params_t  wb_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
    .ex_size(ex_size), .ex_signed(ex_signed), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .stall(stall),
    .mem_fault(mem_fault), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .wb_params_out(wb)
  );

  mem_stage #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
    .ex_size(ex_size), .ex_signed(ex_signed), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .stall(stall_to),
    .mem_fault(fault_to), .dbus_req(req_to), .dbus_we(we_to),
    .dbus_addr(addr_to), .dbus_be(be_to), .dbus_wdata(wdata_to),
    .dbus_ack(dbus_ack_to), .dbus_rdata(dbus_rdata), .wb_params_out(wb_to)
  );

  function automatic wb_params_t mk(input logic [4:0] r, input logic [31:0] d, input mem_op_t o);
    mk = '{rd_addr: r, rd_data: d, mem_op: o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_op = op; ex_size = sz; ex_signed = sg;
    ex_addr = a; ex_store_data = d; ex_rd_addr = rd;
  endtask

  task automatic do_reset();
    ex_valid = 1'b0; dbus_ack = 1'b0; dbus_ack_to = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0;
    tick(); tick();
    checks++; if (dbus_req !== 1'b0 || stall !== 1'b0 || mem_fault !== 1'b0) begin
      errors++; $display("FAIL reset_ctl req=%b stall=%b fault=%b expected 0 0 0", dbus_req, stall, mem_fault); end
    checks++; if (dbus_addr !== 32'h0 || dbus_be !== 4'h0 || dbus_wdata !== 32'h0 || dbus_we !== 1'b0) begin
      errors++; $display("FAIL reset_bus addr=%h be=%h wdata=%h we=%b expected zeros", dbus_addr, dbus_be, dbus_wdata, dbus_we); end
    checks++; if (wb !== mk(5'd0, 32'd0, MEM_OP_NONE)) begin
      errors++; $display("FAIL reset_wb got %h expected bubble", wb); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(2'd0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    #1;
    checks++; if (wb !== mk(5'd5, 32'h1234, MEM_OP_NONE) || stall !== 1'b0) begin
      errors++; $display("FAIL alu_pass got %h stall=%b expected {5,1234,NONE} stall=0", wb, stall); end
    tick();
    drive(2'd3, 2'd0, 1'b0, 32'h0000_0ABD, 32'h0, 5'd6);
    #1;
    checks++; if (wb !== mk(5'd6, 32'h0ABD, MEM_OP_NONE) || stall !== 1'b0) begin
      errors++; $display("FAIL alu_reserved got %h stall=%b expected {6,abd,NONE} stall=0", wb, stall); end
    tick();
    ex_valid = 1'b0;
    checks++; if (dbus_req !== 1'b0) begin
      errors++; $display("FAIL alu_noreq req=%b expected 0", dbus_req); end
  endtask

  task automatic test_load_byte();
    drive(2'd1, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 5'd7);
    #1;
    checks++; if (stall !== 1'b1 || wb !== mk(5'd0, 32'd0, MEM_OP_NONE)) begin
      errors++; $display("FAIL lb_idle stall=%b wb=%h expected stall=1 bubble", stall, wb); end
    tick();
    dbus_ack = 1'b1; dbus_rdata = 32'h80FF_0000;
    #1;
    checks++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h1000 || dbus_be !== 4'b1000 || dbus_we !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL lb_req req=%b addr=%h be=%b we=%b stall=%b expected 1 1000 1000 0 1", dbus_req, dbus_addr, dbus_be, dbus_we, stall); end
    tick();
    dbus_ack = 1'b0;
    #1;
    checks++; if (wb !== mk(5'd7, 32'hFFFF_FF80, MEM_OP_LOAD) || stall !== 1'b0 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL lb_done wb=%h stall=%b req=%b expected {7,ffffff80,LOAD} 0 0", wb, stall, dbus_req); end
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic test_store_half();
    drive(2'd2, 2'd1, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 5'd9);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_be !== 4'b1100 || dbus_wdata !== 32'hBEEF_BEEF || dbus_addr !== 32'h2000 || stall !== 1'b1) begin
        errors++; $display("FAIL sh_hold%0d req=%b we=%b be=%b wdata=%h addr=%h stall=%b expected 1 1 1100 beefbeef 2000 1", i, dbus_req, dbus_we, dbus_be, dbus_wdata, dbus_addr, stall); end
      tick();
    end
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    #1;
    checks++; if (wb !== mk(5'd0, 32'd0, MEM_OP_STORE) || stall !== 1'b0) begin
      errors++; $display("FAIL sh_done wb=%h stall=%b expected {0,0,STORE} 0", wb, stall); end
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    drive(2'd1, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 5'd8);
    #1;
    checks++; if (stall !== 1'b0 || wb !== mk(5'd0, 32'd0, MEM_OP_NONE) || mem_fault !== 1'b0) begin
      errors++; $display("FAIL mis_idle stall=%b wb=%h fault=%b expected 0 bubble 0", stall, wb, mem_fault); end
    tick();
    ex_valid = 1'b0;
    checks++; if (mem_fault !== 1'b1 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL mis_fault fault=%b req=%b expected 1 0", mem_fault, dbus_req); end
    tick();
    checks++; if (mem_fault !== 1'b0 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL mis_pulse fault=%b req=%b expected 0 0", mem_fault, dbus_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(2'd1, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 5'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_to !== 1'b1 || fault_to !== 1'b0 || stall_to !== 1'b1) begin
        errors++; $display("FAIL to_req%0d req=%b fault=%b stall=%b expected 1 0 1", i, req_to, fault_to, stall_to); end
      tick();
    end
    #1;
    checks++; if (req_to !== 1'b0 || fault_to !== 1'b1 || stall_to !== 1'b0 || wb_to !== mk(5'd0, 32'd0, MEM_OP_NONE)) begin
      errors++; $display("FAIL to_abort req=%b fault=%b stall=%b wb=%h expected 0 1 0 bubble", req_to, fault_to, stall_to, wb_to); end
    tick();
    ex_valid = 1'b0;
    checks++; if (req_to !== 1'b0 || fault_to !== 1'b0) begin
      errors++; $display("FAIL to_after req=%b fault=%b expected 0 0", req_to, fault_to); end
    drive(2'd1, 2'd2, 1'b0, 32'h0000_4004, 32'h0, 5'd3);
    tick();
    tick(); tick(); tick();
    dbus_ack_to = 1'b1; dbus_rdata = 32'h1234_5678;
    tick();
    dbus_ack_to = 1'b0;
    #1;
    checks++; if (wb_to !== mk(5'd3, 32'h1234_5678, MEM_OP_LOAD) || fault_to !== 1'b0) begin
      errors++; $display("FAIL to_lastack wb=%h fault=%b expected {3,12345678,LOAD} 0", wb_to, fault_to); end
    tick();
    ex_valid = 1'b0;
    checks++; if (fault_to !== 1'b0 || req_to !== 1'b0) begin
      errors++; $display("FAIL to_nofault fault=%b req=%b expected 0 0", fault_to, req_to); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    drive(2'd1, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 5'd4);
    tick();
    checks++; if (dbus_req !== 1'b1) begin
      errors++; $display("FAIL rm_req req=%b expected 1", dbus_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dbus_req !== 1'b0 || stall !== 1'b0 || wb !== mk(5'd0, 32'd0, MEM_OP_NONE)) begin
      errors++; $display("FAIL rm_async req=%b stall=%b wb=%h expected 0 0 bubble", dbus_req, stall, wb); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL rm_restart stall=%b expected 1", stall); end
    tick();
    dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_BABE;
    tick();
    dbus_ack = 1'b0;
    #1;
    checks++; if (wb !== mk(5'd4, 32'hCAFE_BABE, MEM_OP_LOAD) || mem_fault !== 1'b0) begin
      errors++; $display("FAIL rm_done wb=%h fault=%b expected {4,cafebabe,LOAD} 0", wb, mem_fault); end
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(2'd1, 2'd1, 1'b0, 32'h0000_1002, 32'h0, 5'd2);
    tick();
    dbus_ack = 1'b1; dbus_rdata = 32'h8001_7FFF;
    #1;
    checks++; if (dbus_be !== 4'b1100 || dbus_addr !== 32'h1000) begin
      errors++; $display("FAIL b2b_lhbe be=%b addr=%h expected 1100 1000", dbus_be, dbus_addr); end
    tick();
    dbus_ack = 1'b0;
    #1;
    checks++; if (wb !== mk(5'd2, 32'h0000_8001, MEM_OP_LOAD)) begin
      errors++; $display("FAIL b2b_lhu wb=%h expected {2,00008001,LOAD}", wb); end
    tick();
    drive(2'd2, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A5, 5'd11);
    #1;
    checks++; if (stall !== 1'b1 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL b2b_gap stall=%b req=%b expected 1 0", stall, dbus_req); end
    tick();
    dbus_ack = 1'b1;
    #1;
    checks++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_be !== 4'b0010 || dbus_wdata !== 32'hA5A5_A5A5 || dbus_addr !== 32'h0100) begin
      errors++; $display("FAIL b2b_sb req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 0010 a5a5a5a5 100", dbus_req, dbus_we, dbus_be, dbus_wdata, dbus_addr); end
    tick();
    dbus_ack = 1'b0;
    #1;
    checks++; if (wb !== mk(5'd0, 32'd0, MEM_OP_STORE)) begin
      errors++; $display("FAIL b2b_sbdone wb=%h expected {0,0,STORE}", wb); end
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the MINAv2 core; the producer side of the MEM/WB interface.
- Takes the instruction from EX/MEM, runs any load/store on the data bus with a req/ack handshake, aligns and extends load data, and drives wb_params_t into the MEM/WB register.
- Stalls upstream while a bus transaction is pending.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 255, cycles in REQ without ack before the access is aborted as a bus fault; must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_op  in  2  0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE)
- ex_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- ex_signed  in  1  sign-extend load result
- ex_addr  in  XLEN  effective address / ALU result
- ex_store_data  in  XLEN  store data, right-aligned
- ex_rd_addr  in  5  destination register; 0 = none
- stall  out  1  hold EX/MEM and earlier stages
- mem_fault  out  1  one-cycle pulse: misaligned access or bus timeout
- dbus_req  out  1  bus request
- dbus_we  out  1  write strobe
- dbus_addr  out  XLEN  word-aligned address (low 2 bits zero)
- dbus_be  out  4  byte enables
- dbus_wdata  out  XLEN  lane-replicated store data
- dbus_ack  in  1  bus completion, valid only while dbus_req=1
- dbus_rdata  in  XLEN  read data, valid with dbus_ack
- wb_params_out  out  wb_params_t  {rd_addr, rd_data, mem_op} to MEM/WB

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE immediately.
  - dbus_req=0, dbus_we=0, dbus_be=0, dbus_addr=0, dbus_wdata=0, mem_fault=0, stall=0.
  - wb_params_out={0,0,MEM_OP_NONE}.
  - Reset mid-transaction drops dbus_req in the same cycle; no completion is reported.
- Bubble: wb_params_out={0,0,MEM_OP_NONE}.
- FSM states are IDLE, REQ and DONE. All dbus_* outputs and the capture registers are flopped.
- IDLE, ex_valid=0: output a bubble; stall=0.
- IDLE, ex_valid=1, op NONE:
  - Combinational pass-through: wb_params_out={ex_rd_addr, ex_addr, MEM_OP_NONE}.
  - stall=0. Zero added latency.
- IDLE, ex_valid=1, op LOAD/STORE, misaligned (half with addr[0]=1, or word with addr[1:0]≠0):
  - No bus access. Output a bubble. stall=0.
  - mem_fault=1 on the next cycle for exactly one cycle.
- IDLE, ex_valid=1, op LOAD/STORE, aligned:
  - stall=1 and output a bubble.
  - Capture rd_addr, op, size, signed and addr[1:0].
  - Next edge: dbus_req=1, dbus_addr={addr[XLEN-1:2],2'b00}, dbus_we=(op==STORE).
  - Byte enables: byte → 1<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
  - Store data: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
  - Go to REQ.
- REQ:
  - stall=1, output a bubble, all dbus_* held stable.
  - The timeout counter increments each cycle.
  - dbus_ack=1: capture dbus_rdata, drop dbus_req next edge, go to DONE.
  - Counter reaches TIMEOUT without ack: drop dbus_req, pulse mem_fault, go to IDLE, output a bubble.
  - ack and timeout in the same cycle: ack wins.
- DONE (one cycle, stall=0, EX inputs ignored):
  - LOAD: rd_data = lane addr[1:0] (byte) or addr[1] (half) of the captured data, zero- or sign-extended per signed; wb_params_out={rd, rd_data, LOAD}.
  - STORE: wb_params_out={0, 0, STORE}.
  - Next state IDLE. The instruction held in EX/MEM during DONE is consumed by the advance at the end of DONE.
- Load minimum latency: 3 cycles (IDLE→REQ→DONE) with ack on the first REQ cycle.
- Back-to-back memory ops: each op gets its own IDLE evaluation cycle; no pipelining of bus requests.
- Load to rd=0: the bus access is performed; rd_addr=0 is forwarded and WB discards it.

Test Plan:
- ALU op, ex_rd_addr=5, ex_addr=0x1234 → same cycle wb_params_out={5,0x1234,NONE}, stall=0, dbus_req stays 0.
- Signed byte LOAD, addr=0x1003, ack with rdata=0x80FF_0000 on first REQ cycle → dbus_addr=0x1000, be=4'b1000; in DONE rd_data=0xFFFF_FF80; stall high for exactly 2 cycles.
- Half STORE, addr=0x2002, data=0xDEAD_BEEF, ack delayed 4 cycles → dbus_we=1, be=4'b1100, wdata=0xBEEF_BEEF, all held stable throughout REQ; DONE outputs {0,0,STORE}.
- Word LOAD at addr=0x3001 → no dbus_req, mem_fault pulses 1 cycle, bubble output, stall=0.
- TIMEOUT=4, no ack → dbus_req high 4 cycles then low, mem_fault pulses once, FSM back to IDLE; ack arriving on the 4th cycle → normal completion, no fault.
- Assert rst_n=0 during REQ → dbus_req, stall and wb_params_out at reset values immediately; after release a fresh LOAD completes normally.
